meas_seq_ctrl: RTL
==================

Name: meas_seq_ctrl

Overview:
Parametrised measurement sequencer that drives the DAC transmit path and the ADC/FIFO receive path over one or more shots. A shot is: FIFO reset, transmit, receive, then a gap before the next shot.
- Replaces the single-shot key-driven controller.
- Adds: shot count, continuous mode, abort, inter-shot gap, transmit/receive timeout with a sticky error.
- Sits in the clk_100 domain between the key/host trigger and the Tx/Re blocks.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles key_in must be stable before a level change is accepted
FIFO_RST_CYCLES, 16, cycles fifo_rst is held high before each shot
GAP_CYCLES, 1000, idle cycles between consecutive shots
TIMEOUT_CYCLES, 65536, maximum cycles in TX or RX without the matching over signal
SHOT_W, 8, width of shot count fields

Ports:
clk_100  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
key_in  in  1  raw push-button, active low, asynchronous
start_pulse  in  1  host start, one-cycle pulse
abort  in  1  host abort, level sampled each cycle
mode_cont  in  1  0 = run num_shots shots; 1 = run until abort
num_shots  in  SHOT_W  shots per run, latched at trigger
tx_over  in  1  transmit burst complete, pulse from Tx
re_over  in  1  receive capture complete, pulse from Re
tx_en  out  1  enables Tx burst; also drives ADC enable at top level
re_en  out  1  enables Re capture
begin_signal  out  1  one-cycle pulse at start of each shot's TX
fifo_rst  out  1  receive FIFO reset
busy  out  1  high from trigger until return to IDLE; drives temp_led
done  out  1  one-cycle pulse on normal completion
timeout_err  out  1  sticky timeout flag
shot_cnt  out  SHOT_W  completed shots in current run
state  out  3  current FSM state code for debug

Behaviour:
- All outputs are registered. On rst, all outputs are 0, FSM is IDLE, and the debounce filter is 1 (released).
- rst mid-run returns to IDLE on the next edge. No done pulse.
- Key path:
  - 2-FF synchroniser, then a counter.
  - Filtered level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A filtered 1->0 transition produces key_press, one cycle.
- trigger = start_pulse OR key_press, acted on only in IDLE. start_pulse outside IDLE is ignored.
- stop = abort OR key_press, acted on only when not IDLE.
- States: IDLE=0, FRST=1, TX=2, RX=3, GAP=4, DONE=5.
- IDLE:
  - On trigger at edge N:
    - Latch target = max(num_shots,1).
    - Latch cont = mode_cont.
    - Clear shot_cnt and timeout_err.
  - busy=1 and state=FRST from N+1.
- FRST: fifo_rst=1 for exactly FIFO_RST_CYCLES cycles, then TX.
- TX:
  - tx_en=1 for the whole state.
  - begin_signal=1 on the first TX cycle only.
  - tx_over -> RX on the next edge.
- RX:
  - re_en=1, tx_en=0.
  - On re_over, shot_cnt increments with saturation at all-ones.
  - If cont=0 and the incremented count equals target -> DONE. Otherwise -> GAP.
- GAP: all enables low for GAP_CYCLES cycles, then FRST.
- DONE: done=1 for one cycle, then IDLE with busy=0 the same edge.
- Timeout:
  - A single counter restarts on entry to TX and on entry to RX.
  - If it reaches TIMEOUT_CYCLES without the matching over signal: timeout_err=1, go to IDLE, no done pulse.
- stop in any non-IDLE state: go to IDLE on the next edge, all enables low, no done pulse, shot_cnt holds its value.
- Priority within one cycle: rst > stop > over signal > timeout expiry.
  - An over signal arriving on the expiry cycle counts as success.
- tx_over outside TX and re_over outside RX are ignored.
- shot_cnt and timeout_err hold their values in IDLE until the next trigger.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, FIFO_RST_CYCLES=3, GAP_CYCLES=5, TIMEOUT_CYCLES=20, SHOT_W=8.)
- Single-shot run.
  - Stimulus: start_pulse with num_shots=1, mode_cont=0; tx_over 10 cycles into TX; re_over 8 cycles into RX.
  - Required: fifo_rst high exactly 3 cycles; begin_signal one pulse; tx_en 10 cycles, then re_en; done pulse; shot_cnt=1; busy=0 after DONE.
- Multi-shot run.
  - Stimulus: num_shots=3.
  - Required: 3 FRST/TX/RX cycles with 5-cycle gaps; 3 begin_signal pulses; one done; shot_cnt=3.
  - Stimulus: num_shots=0.
  - Required: behaves as 1 shot.
- Continuous mode.
  - Stimulus: mode_cont=1, 4 shots complete, then abort during the 5th TX.
  - Required: tx_en low next cycle; no done; shot_cnt=4; state=IDLE.
- Timeout.
  - Stimulus: tx_over never arrives.
  - Required: timeout_err=1 after 20 TX cycles; return to IDLE; no done.
  - Stimulus: next start_pulse.
  - Required: timeout_err clears.
  - Stimulus: tx_over on the 20th cycle.
  - Required: proceeds to RX with no error.
- Key debounce.
  - Stimulus: 3-cycle low glitch.
  - Required: no trigger.
  - Stimulus: 6-cycle low.
  - Required: one trigger.
  - Stimulus: key press while busy.
  - Required: abort to IDLE.
  - Stimulus: start_pulse while busy.
  - Required: ignored.
- Reset mid-run.
  - Stimulus: rst asserted in RX.
  - Required: all outputs 0 at the next edge.
  - Stimulus: start_pulse after rst release.
  - Required: a fresh run starts.

Source files
------------

// File: rtl/meas_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// meas_seq_ctrl_if
//   Host/datapath bundle for the measurement sequencer.
//   master : the trigger/host side plus the Tx/Re completion pulses
//            (start_pulse, abort, mode_cont, num_shots, tx_over, re_over)
//   slave  : the sequencer itself, which drives the enables and status
//            (tx_en, re_en, begin_signal, fifo_rst, busy, done,
//             timeout_err, shot_cnt, state)
// ---------------------------------------------------------------------------
interface meas_seq_ctrl_if #(
  parameter int SHOT_W = 8
);
  logic              start_pulse;
  logic              abort;
  logic              mode_cont;
  logic [SHOT_W-1:0] num_shots;
  logic              tx_over;
  logic              re_over;

  logic              tx_en;
  logic              re_en;
  logic              begin_signal;
  logic              fifo_rst;
  logic              busy;
  logic              done;
  logic              timeout_err;
  logic [SHOT_W-1:0] shot_cnt;
  logic [2:0]        state;

  modport master (
    output start_pulse, abort, mode_cont, num_shots, tx_over, re_over,
    input  tx_en, re_en, begin_signal, fifo_rst, busy, done,
           timeout_err, shot_cnt, state
  );

  modport slave (
    input  start_pulse, abort, mode_cont, num_shots, tx_over, re_over,
    output tx_en, re_en, begin_signal, fifo_rst, busy, done,
           timeout_err, shot_cnt, state
  );
endinterface

// File: rtl/meas_seq_ctrl.sv
// ---------------------------------------------------------------------------
// meas_seq_ctrl
//   Multi-shot measurement sequencer in the clk_100 domain. Each shot runs
//   FIFO reset -> transmit -> receive, with an idle gap between shots.
//   A run is started by a host start pulse or a debounced key press, and
//   stopped by host abort, a key press, completion, or a TX/RX timeout.
//
// Ports
//   clk_100 : system clock, rising edge
//   rst     : synchronous active-high reset
//   key_in  : raw active-low push-button (asynchronous)
//   bus     : slave side of meas_seq_ctrl_if (host controls, Tx/Re
//             completion pulses in; enables, pulses and status out)
// ---------------------------------------------------------------------------
module meas_seq_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FIFO_RST_CYCLES = 16,
  parameter int GAP_CYCLES      = 1000,
  parameter int TIMEOUT_CYCLES  = 65536,
  parameter int SHOT_W          = 8
) (
  input  logic           clk_100,
  input  logic           rst,
  input  logic           key_in,
  meas_seq_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FRST = 3'd1;
  localparam logic [2:0] ST_TX   = 3'd2;
  localparam logic [2:0] ST_RX   = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  // One shared phase counter covers FIFO reset, gap and TX/RX timeout;
  // it only ever needs to reach the largest limit minus one.
  localparam int MAX_FG  = (FIFO_RST_CYCLES > GAP_CYCLES) ? FIFO_RST_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_FG > TIMEOUT_CYCLES) ? MAX_FG : TIMEOUT_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // Key path
  logic            key_sync1_q, key_sync1_d;
  logic            key_sync2_q, key_sync2_d;
  logic            key_filt_q,  key_filt_d;
  logic [DB_W-1:0] db_cnt_q,    db_cnt_d;
  logic            key_press_q, key_press_d;

  // Sequencer state
  logic [2:0]        state_q,       state_d;
  logic [CNT_W-1:0]  cnt_q,         cnt_d;
  logic [SHOT_W-1:0] shot_cnt_q,    shot_cnt_d;
  logic [SHOT_W-1:0] target_q,      target_d;
  logic              cont_q,        cont_d;
  logic              timeout_err_q, timeout_err_d;

  // Registered outputs
  logic tx_en_q,    tx_en_d;
  logic re_en_q,    re_en_d;
  logic begin_q,    begin_d;
  logic fifo_rst_q, fifo_rst_d;
  logic busy_q,     busy_d;
  logic done_q,     done_d;

  logic              trigger;
  logic              stop;
  logic              tmo_hit;
  logic [SHOT_W-1:0] shot_inc;

  // ---------------- key synchroniser and debounce ----------------
  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    key_sync1_d = key_in;
    key_sync2_d = key_sync1_q;
    key_filt_d  = key_filt_q;
    db_cnt_d    = '0;
    // Count consecutive samples that disagree with the filtered level; any
    // agreeing sample restarts the count.
    if (key_sync2_q != key_filt_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        key_filt_d = key_sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
    key_press_d = key_filt_q & ~key_filt_d;
  end

  // ---------------- sequencer ----------------
  always_comb begin
    trigger       = bus.start_pulse | key_press_q;
    stop          = bus.abort | key_press_q;
    tmo_hit       = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    shot_inc      = (shot_cnt_q == '1) ? shot_cnt_q : shot_cnt_q + SHOT_W'(1);
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_W'(1);
    shot_cnt_d    = shot_cnt_q;
    target_d      = target_q;
    cont_d        = cont_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d       = ST_FRST;
          target_d      = (bus.num_shots == '0) ? SHOT_W'(1) : bus.num_shots;
          cont_d        = bus.mode_cont;
          shot_cnt_d    = '0;
          timeout_err_d = 1'b0;
        end
      end
      ST_FRST: begin
        if (cnt_q == CNT_W'(FIFO_RST_CYCLES - 1)) state_d = ST_TX;
      end
      ST_TX: begin
        // Completion wins over expiry on the same cycle.
        if (bus.tx_over) begin
          state_d = ST_RX;
        end else if (tmo_hit) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end
      end
      ST_RX: begin
        if (bus.re_over) begin
          shot_cnt_d = shot_inc;
          state_d    = (!cont_q && shot_inc == target_q) ? ST_DONE : ST_GAP;
        end else if (tmo_hit) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = ST_FRST;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Stop outranks every in-state decision, including a same-cycle
    // re_over, so the shot count and error flag are left untouched.
    if (state_q != ST_IDLE && stop) begin
      state_d       = ST_IDLE;
      shot_cnt_d    = shot_cnt_q;
      timeout_err_d = timeout_err_q;
    end

    // Any state change restarts the phase counter; IDLE keeps it parked.
    if (state_d != state_q || state_d == ST_IDLE) cnt_d = '0;

    // Outputs are registered from the next state so they line up with
    // the state register.
    tx_en_d    = (state_d == ST_TX);
    re_en_d    = (state_d == ST_RX);
    begin_d    = (state_d == ST_TX) && (state_q != ST_TX);
    fifo_rst_d = (state_d == ST_FRST);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  // NOTE: all state updates use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      key_sync1_q   <= 1'b1;
      key_sync2_q   <= 1'b1;
      key_filt_q    <= 1'b1;
      db_cnt_q      <= '0;
      key_press_q   <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      shot_cnt_q    <= '0;
      target_q      <= '0;
      cont_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      tx_en_q       <= 1'b0;
      re_en_q       <= 1'b0;
      begin_q       <= 1'b0;
      fifo_rst_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      key_sync1_q   <= key_sync1_d;
      key_sync2_q   <= key_sync2_d;
      key_filt_q    <= key_filt_d;
      db_cnt_q      <= db_cnt_d;
      key_press_q   <= key_press_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shot_cnt_q    <= shot_cnt_d;
      target_q      <= target_d;
      cont_q        <= cont_d;
      timeout_err_q <= timeout_err_d;
      tx_en_q       <= tx_en_d;
      re_en_q       <= re_en_d;
      begin_q       <= begin_d;
      fifo_rst_q    <= fifo_rst_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.tx_en        = tx_en_q;
  assign bus.re_en        = re_en_q;
  assign bus.begin_signal = begin_q;
  assign bus.fifo_rst     = fifo_rst_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.shot_cnt     = shot_cnt_q;
  assign bus.state        = state_q;

endmodule
